// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : wb_arbiter
// Description : Writeback arbiter. Four per-source holding entries drain into
//               two regfile write ports in round-robin order.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int PREGW = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic [3:0]           i_valid,
  input  logic [4*PREGW-1:0]   i_tag,
  input  logic [4*WIDTH-1:0]   i_data,
  output logic [3:0]           o_ready,
  output logic [1:0]           o_we,
  output logic [2*PREGW-1:0]   o_wtag,
  output logic [2*WIDTH-1:0]   o_wdata,
  output logic [3:0]           o_wsrc,
  output logic [2:0]           o_pending
);

  logic [3:0]       r_hv;
  logic [PREGW-1:0] r_htag  [4];
  logic [WIDTH-1:0] r_hdata [4];
  logic [1:0]       r_p;

  logic       w_active;
  logic       w_g0_vld;
  logic       w_g1_vld;
  logic [1:0] w_g0_src;
  logic [1:0] w_g1_src;
  logic [3:0] w_grant;
  logic [3:0] w_accept;

  assign w_active = !i_rst && !i_flush;

  // Scan from the round-robin pointer; first two held entries win the ports.
  always_comb begin
    logic [1:0] w_scan;
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0_src = 2'd0;
    w_g1_src = 2'd0;
    w_scan   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_scan = r_p + 2'(i);
      if (r_hv[w_scan]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_src = w_scan;
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_src = w_scan;
        end
      end
    end
  end

  always_comb begin
    w_grant = 4'b0000;
    if (w_active) begin
      if (w_g0_vld) w_grant[w_g0_src] = 1'b1;
      if (w_g1_vld) w_grant[w_g1_src] = 1'b1;
    end
  end

  always_comb begin
    o_we      = 2'b00;
    o_wtag    = '0;
    o_wdata   = '0;
    o_wsrc    = 4'b0000;
    if (w_active && w_g0_vld) begin
      o_we[0]            = 1'b1;
      o_wtag[0 +: PREGW] = r_htag[w_g0_src];
      o_wdata[0 +: WIDTH] = r_hdata[w_g0_src];
      o_wsrc[1:0]        = w_g0_src;
    end
    if (w_active && w_g1_vld) begin
      o_we[1]                = 1'b1;
      o_wtag[PREGW +: PREGW] = r_htag[w_g1_src];
      o_wdata[WIDTH +: WIDTH] = r_hdata[w_g1_src];
      o_wsrc[3:2]            = w_g1_src;
    end
  end

  // A granted entry frees up in the same cycle, so it can refill immediately.
  assign o_ready  = (~r_hv | w_grant) & {4{w_active}};
  assign w_accept = i_valid & o_ready;

  assign o_pending = {2'b00, r_hv[0]} + {2'b00, r_hv[1]}
                   + {2'b00, r_hv[2]} + {2'b00, r_hv[3]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hv <= 4'b0000;
      r_p  <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        r_htag[k]  <= '0;
        r_hdata[k] <= '0;
      end
    end else if (i_flush) begin
      r_hv <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept[k]) begin
          r_hv[k]    <= 1'b1;
          r_htag[k]  <= i_tag[k*PREGW +: PREGW];
          r_hdata[k] <= i_data[k*WIDTH +: WIDTH];
        end else if (w_grant[k]) begin
          r_hv[k] <= 1'b0;
        end
      end
      if (w_g1_vld)      r_p <= w_g1_src + 2'd1;
      else if (w_g0_vld) r_p <= w_g0_src + 2'd1;
    end
  end

endmodule

`default_nettype wire
